libar_key_sequencer: RTL and testbench

Loads the 16-bit logic-locking key for the LIBAR-obfuscated c432 core from a serial key source, checks it against a parity bit, and drives the `keyinput0..keyinput15` bus. It holds `key_apply` for a fixed settle window so the internally clocked LIBAR key latches capture a stable key. It also counts failed loads and enters a permanent lockout, cleared only by reset, after too many failures. It sits between the key-storage interface and the locked netlist in the simulator testbench.

---
 rtl/libar_key_sequencer_if.sv | 42 ++++
 rtl/libar_key_sequencer.sv | 170 +++++++++++++++++
 tb/tb_libar_key_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/libar_key_sequencer_if.sv
// Key-storage side bundle for the LIBAR key sequencer.
// master: the serial key source and its observer; slave: the sequencer itself.
interface libar_key_sequencer_if #(
    parameter int unsigned KEY_W = 16
);
    logic             load_start;
    logic             key_bit;
    logic             key_bit_valid;
    logic [KEY_W-1:0] key_out;
    logic             key_apply;
    logic             ready;
    logic             busy;
    logic             err;
    logic             lockout;
    logic [1:0]       fail_cnt;

    modport master (
        output load_start,
        output key_bit,
        output key_bit_valid,
        input  key_out,
        input  key_apply,
        input  ready,
        input  busy,
        input  err,
        input  lockout,
        input  fail_cnt
    );

    modport slave (
        input  load_start,
        input  key_bit,
        input  key_bit_valid,
        output key_out,
        output key_apply,
        output ready,
        output busy,
        output err,
        output lockout,
        output fail_cnt
    );
endinterface

// File: rtl/libar_key_sequencer.sv
// Serial key loader for the LIBAR-locked c432: shifts in KEY_W key bits plus a
// parity bit, verifies parity, drives keyinput0..KEY_W-1 and holds key_apply for
// SETTLE cycles so the internal key latches capture a stable value. Repeated
// parity failures lead to a lockout that only rst clears.
module libar_key_sequencer #(
    parameter int unsigned KEY_W    = 16,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned MAX_FAIL = 3
) (
    input logic                  clk,
    input logic                  rst,
    libar_key_sequencer_if.slave kif
);

    localparam int unsigned BCW = $clog2(KEY_W + 1);
    localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // Bit counter value at which the parity bit arrives.
    localparam logic [BCW-1:0] PAR_IDX     = BCW'(KEY_W);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [1:0]     FAIL_LIMIT  = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StApply,
        StReady,
        StLockout
    } state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic             parity_q, parity_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [1:0]       fail_cnt_q, fail_cnt_d;
    logic             err_q, err_d;
    logic             key_apply_q, key_apply_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             lockout_q, lockout_d;

    logic [1:0]       fail_next;
    logic             parity_ok;

    assign parity_ok = ((^shadow_q) == parity_q);
    // Saturating increment; CHECK never runs with the count already at the limit.
    assign fail_next = (fail_cnt_q == FAIL_LIMIT) ? fail_cnt_q : fail_cnt_q + 2'd1;

    // Next-state logic for the load / check / apply / lockout sequence.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;
        key_d        = key_q;
        fail_cnt_d   = fail_cnt_q;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle, StReady: begin
                if (kif.load_start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
                end
            end

            StLoad: begin
                if (kif.load_start) begin
                    // Restart: the shadow is simply overwritten by the new bits.
                    bit_cnt_d = '0;
                end else if (kif.key_bit_valid) begin
                    if (bit_cnt_q == PAR_IDX) begin
                        parity_d = kif.key_bit;
                        state_d  = StCheck;
                    end else begin
                        // Shift in from the top so the first bit ends in shadow[0].
                        shadow_d  = {kif.key_bit, shadow_q[KEY_W-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            StCheck: begin
                if (parity_ok) begin
                    key_d        = shadow_q;
                    fail_cnt_d   = 2'd0;
                    settle_cnt_d = '0;
                    state_d      = StApply;
                end else begin
                    err_d      = 1'b1;
                    fail_cnt_d = fail_next;
                    if (fail_next == FAIL_LIMIT) begin
                        key_d   = '0;
                        state_d = StLockout;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            StApply: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = StReady;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end

            StLockout: begin
                key_d = '0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status flags are decoded from the next state so they leave on flops.
    always_comb begin
        key_apply_d = (state_d == StApply);
        ready_d     = (state_d == StReady);
        busy_d      = (state_d == StLoad) || (state_d == StCheck) || (state_d == StApply);
        lockout_d   = (state_d == StLockout);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            shadow_q     <= '0;
            parity_q     <= 1'b0;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            key_q        <= '0;
            fail_cnt_q   <= 2'd0;
            err_q        <= 1'b0;
            key_apply_q  <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            parity_q     <= parity_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            key_q        <= key_d;
            fail_cnt_q   <= fail_cnt_d;
            err_q        <= err_d;
            key_apply_q  <= key_apply_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            lockout_q    <= lockout_d;
        end
    end

    assign kif.key_out   = key_q;
    assign kif.key_apply = key_apply_q;
    assign kif.ready     = ready_q;
    assign kif.busy      = busy_q;
    assign kif.err       = err_q;
    assign kif.lockout   = lockout_q;
    assign kif.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_libar_key_sequencer.sv
// Directed bench for libar_key_sequencer: good loads, stalled loads, parity
// failures into lockout, recovery of the fail counter, restart and reset-in-APPLY.
module tb_libar_key_sequencer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    libar_key_sequencer_if #(.KEY_W(16)) kif ();

    libar_key_sequencer #(
        .KEY_W   (16),
        .SETTLE  (4),
        .MAX_FAIL(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; all driving and sampling happens 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        kif.load_start = 1'b1;
        tick();
        kif.load_start = 1'b0;
    endtask

    // Sends 16 key bits LSB first then the parity bit; returns in cycle M+1.
    task automatic send_key(input logic [15:0] k, input logic p, input bit stall);
        for (int i = 0; i < 17; i++) begin
            kif.key_bit       = (i < 16) ? k[i] : p;
            kif.key_bit_valid = 1'b1;
            tick();
            if (stall && i < 16) begin
                kif.key_bit_valid = 1'b0;
                kif.key_bit       = ~kif.key_bit;
                tick();
            end
        end
        kif.key_bit_valid = 1'b0;
        kif.key_bit       = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!kif.ready && n < 30) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(kif.ready), 32'd1);
    endtask

    task automatic check_reset_outs(input string pfx);
        check_eq({pfx, "_key_out"}, 32'(kif.key_out), 32'h0);
        check_eq({pfx, "_ready"}, 32'(kif.ready), 32'd0);
        check_eq({pfx, "_busy"}, 32'(kif.busy), 32'd0);
        check_eq({pfx, "_err"}, 32'(kif.err), 32'd0);
        check_eq({pfx, "_lockout"}, 32'(kif.lockout), 32'd0);
        check_eq({pfx, "_key_apply"}, 32'(kif.key_apply), 32'd0);
        check_eq({pfx, "_fail_cnt"}, 32'(kif.fail_cnt), 32'd0);
    endtask

    // Load 0xA5C3 (even parity) from IDLE/READY and run to READY.
    task automatic good_a5c3(input string pfx);
        int cnt;
        start_load();
        check_eq({pfx, "_busy_load"}, 32'(kif.busy), 32'd1);
        send_key(16'hA5C3, 1'b0, 1'b0);
        check_eq({pfx, "_busy_check"}, 32'(kif.busy), 32'd1);
        tick();
        check_eq({pfx, "_key_m2"}, 32'(kif.key_out), 32'h0000A5C3);
        check_eq({pfx, "_apply_m2"}, 32'(kif.key_apply), 32'd1);
        cnt = 0;
        while (kif.key_apply && cnt < 20) begin
            // load_start during APPLY must not disturb the settle window
            kif.load_start = (cnt == 0);
            tick();
            kif.load_start = 1'b0;
            cnt++;
        end
        check_eq({pfx, "_apply_len"}, 32'(cnt), 32'd4);
        check_eq({pfx, "_ready_m6"}, 32'(kif.ready), 32'd1);
        check_eq({pfx, "_busy_m6"}, 32'(kif.busy), 32'd0);
        check_eq({pfx, "_fail_m6"}, 32'(kif.fail_cnt), 32'd0);
        check_eq({pfx, "_key_m6"}, 32'(kif.key_out), 32'h0000A5C3);
    endtask

    // Watchdog in case the DUT stops the clocked flow from ever finishing.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        kif.load_start    = 1'b0;
        kif.key_bit       = 1'b0;
        kif.key_bit_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outs("rst");

        // Good load with key_bit_valid held high.
        good_a5c3("a5c3");

        // Stalled load of 0x0001, odd parity.
        start_load();
        send_key(16'h0001, 1'b1, 1'b1);
        check_eq("stall_key_m1", 32'(kif.key_out), 32'h0000A5C3);
        tick();
        check_eq("stall_key_m2", 32'(kif.key_out), 32'h00000001);
        wait_ready("stall_ready");

        // Three parity failures into lockout.
        for (int i = 1; i <= 3; i++) begin
            start_load();
            send_key(16'h0001, 1'b0, 1'b0);
            check_eq($sformatf("bad%0d_err_m1", i), 32'(kif.err), 32'd0);
            tick();
            check_eq($sformatf("bad%0d_err", i), 32'(kif.err), 32'd1);
            check_eq($sformatf("bad%0d_fail", i), 32'(kif.fail_cnt), 32'(i));
            check_eq($sformatf("bad%0d_lockout", i), 32'(kif.lockout), (i == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("bad%0d_key", i), 32'(kif.key_out), (i == 3) ? 32'h0 : 32'h1);
            tick();
            check_eq($sformatf("bad%0d_err_off", i), 32'(kif.err), 32'd0);
        end
        kif.load_start    = 1'b1;
        kif.key_bit_valid = 1'b1;
        kif.key_bit       = 1'b1;
        repeat (20) tick();
        kif.load_start    = 1'b0;
        kif.key_bit_valid = 1'b0;
        kif.key_bit       = 1'b0;
        check_eq("lock_held", 32'(kif.lockout), 32'd1);
        check_eq("lock_busy", 32'(kif.busy), 32'd0);
        check_eq("lock_key", 32'(kif.key_out), 32'h0);
        check_eq("lock_fail", 32'(kif.fail_cnt), 32'd3);
        check_eq("lock_ready", 32'(kif.ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outs("unlock");

        // Two failures then a good key clears the count.
        for (int i = 1; i <= 2; i++) begin
            start_load();
            send_key(16'h0001, 1'b0, 1'b0);
            tick();
            check_eq($sformatf("rec%0d_fail", i), 32'(kif.fail_cnt), 32'(i));
        end
        start_load();
        send_key(16'h1234, 1'b1, 1'b0);
        tick();
        check_eq("rec_fail_clr", 32'(kif.fail_cnt), 32'd0);
        check_eq("rec_key", 32'(kif.key_out), 32'h00001234);
        wait_ready("rec_ready");

        // Restart mid-load from READY with key 0xA5C3.
        good_a5c3("pre");
        start_load();
        send_key_partial: for (int i = 0; i < 5; i++) begin
            kif.key_bit       = 1'b1;
            kif.key_bit_valid = 1'b1;
            tick();
        end
        kif.key_bit_valid = 1'b0;
        start_load();
        check_eq("rs_key_hold", 32'(kif.key_out), 32'h0000A5C3);
        check_eq("rs_busy", 32'(kif.busy), 32'd1);
        send_key(16'h00FF, 1'b0, 1'b0);
        check_eq("rs_key_m1", 32'(kif.key_out), 32'h0000A5C3);
        tick();
        check_eq("rs_key_m2", 32'(kif.key_out), 32'h000000FF);
        check_eq("rs_err", 32'(kif.err), 32'd0);
        wait_ready("rs_ready");
        check_eq("rs_key_final", 32'(kif.key_out), 32'h000000FF);

        // Reset in the middle of APPLY.
        start_load();
        send_key(16'h1234, 1'b1, 1'b0);
        tick();
        tick();
        check_eq("ap_apply", 32'(kif.key_apply), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outs("ap_rst");
        rst = 1'b0;
        tick();
        check_eq("ap_idle_busy", 32'(kif.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
